// File: rtl/control_desplazamiento.sv
// Sequencer for an N-bit universal shift register: one command per start pulse,
// an optional parallel-load cycle followed by cmd_len shift/rotate steps.
module control_desplazamiento #(
    parameter int N     = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             start,
    input  logic             cmd_load,
    input  logic             cmd_dir,
    input  logic             cmd_rot,
    input  logic [CNT_W-1:0] cmd_len,
    input  logic             pause,
    input  logic             abort,
    output logic [1:0]       modo,
    output logic             dir,
    output logic             clkenb,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining,
    output logic [1:0]       state_dbg
);

    if (N < 1) begin : g_n_check
        $error("control_desplazamiento: N must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_LOAD  = 2'b01,
        S_SHIFT = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic             rot_q, rot_d;
    logic             dir_d;
    logic [CNT_W-1:0] rem_d;
    logic             paused_d;
    logic [1:0]       modo_d;
    logic             clkenb_d, busy_d, done_d;

    assign state_dbg = state_q;

    // Next-state: abort beats pause; a paused SHIFT cycle keeps state and count.
    always_comb begin
        state_d  = state_q;
        rot_d    = rot_q;
        dir_d    = dir;
        rem_d    = remaining;
        paused_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dir_d = cmd_dir;
                    rot_d = cmd_rot;
                    rem_d = cmd_len;
                    if (cmd_load)            state_d = S_LOAD;
                    else if (cmd_len != '0)  state_d = S_SHIFT;
                    else                     state_d = S_DONE;
                end
            end
            S_LOAD: begin
                if (abort)                   state_d = S_IDLE;
                else if (remaining != '0)    state_d = S_SHIFT;
                else                         state_d = S_DONE;
            end
            S_SHIFT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (pause) begin
                    paused_d = 1'b1;
                end else begin
                    rem_d = remaining - 1'b1;
                    if (remaining == CNT_W'(1)) state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they can be registered (Moore).
    always_comb begin
        modo_d   = 2'b00;
        clkenb_d = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        case (state_d)
            S_LOAD: begin
                modo_d   = 2'b01;
                clkenb_d = 1'b1;
                busy_d   = 1'b1;
            end
            S_SHIFT: begin
                busy_d = 1'b1;
                if (!paused_d) begin
                    modo_d   = {1'b1, rot_d};
                    clkenb_d = 1'b1;
                end
            end
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q   <= S_IDLE;
            rot_q     <= 1'b0;
            dir       <= 1'b0;
            remaining <= '0;
            modo      <= 2'b00;
            clkenb    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            rot_q     <= rot_d;
            dir       <= dir_d;
            remaining <= rem_d;
            modo      <= modo_d;
            clkenb    <= clkenb_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule
